// File: rtl/dsp_simd_pkg.sv
// Shared types and helpers for the signed SIMD multiply-accumulate unit.
// Lane widths are 8 << prec; each lane accumulator needs 2*LW + guard bits,
// so the widest lane (64-bit) bounds the accumulator storage.
package dsp_simd_pkg;

    typedef enum logic [1:0] {
        PREC_8  = 2'd0,
        PREC_16 = 2'd1,
        PREC_32 = 2'd2,
        PREC_64 = 2'd3
    } prec_t;

    // Default guard width; MAX_ACC_W is the widest lane accumulator at that default.
    localparam int GUARD_W_DEF = 8;
    localparam int MAX_ACC_W   = 128 + GUARD_W_DEF;

    // Lane width in bits for a given mode.
    function automatic int lane_w(prec_t prec);
        return 8 << prec;
    endfunction

    // Number of lanes a data_w-bit word holds in a given mode.
    function automatic int lane_cnt(prec_t prec, int data_w);
        return data_w / lane_w(prec);
    endfunction

endpackage

// File: rtl/dsp_simd_sat_pack.sv
// Reduces each lane accumulator of the active mode to its lane width and packs
// the lanes into one result word. Purely combinational.
// Build option DSP_SIMD_MAC_SAT_EN: defined -> lanes clamp to the signed lane
// range and ovf flags any clamp; undefined -> lanes keep the low LW bits and
// ovf is constant 0.
module dsp_simd_sat_pack
    import dsp_simd_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ACC_LW = MAX_ACC_W
) (
    input  prec_t                                    prec,
    input  logic [lane_cnt(PREC_8, DATA_W)*ACC_LW-1:0] acc_flat,
    output logic [DATA_W-1:0]                        p,
    output logic                                     ovf
);

    localparam int NL8 = lane_cnt(PREC_8, DATA_W);

    logic [DATA_W-1:0] p_mode [4];
`ifdef DSP_SIMD_MAC_SAT_EN
    logic [NL8-1:0]    clamp_mode [4];
`endif

    for (genvar m = 0; m < 4; m++) begin : g_mode
        localparam int LW = 8 << m;
        localparam int NL = DATA_W / LW;
        for (genvar i = 0; i < NL8; i++) begin : g_lane
            if (i < NL) begin : g_used
                // Lane value, sign-extended to the full accumulator slot width.
                logic [ACC_LW-1:0] v;
                assign v = acc_flat[i*ACC_LW +: ACC_LW];
`ifdef DSP_SIMD_MAC_SAT_EN
                // In range when every bit from the lane sign bit upward agrees.
                logic in_range;
                assign in_range = (&v[ACC_LW-1:LW-1]) | ~(|v[ACC_LW-1:LW-1]);
                assign clamp_mode[m][i] = ~in_range;
                assign p_mode[m][i*LW +: LW] =
                    in_range     ? v[LW-1:0] :
                    v[ACC_LW-1]  ? {1'b1, {(LW-1){1'b0}}} :
                                   {1'b0, {(LW-1){1'b1}}};
`else
                assign p_mode[m][i*LW +: LW] = v[LW-1:0];
`endif
            end else begin : g_idle
`ifdef DSP_SIMD_MAC_SAT_EN
                assign clamp_mode[m][i] = 1'b0;
`endif
            end
        end
    end

    // Select the packed word of the packet's mode.
    always_comb begin
        p = p_mode[prec];
    end

`ifdef DSP_SIMD_MAC_SAT_EN
    assign ovf = |clamp_mode[prec];
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/dsp_simd_mac.sv
// Signed SIMD multiply-accumulate: DATA_W-bit operands split into 8/16/32/64-bit
// lanes, each lane accumulating over a multi-beat packet; one packed result per
// packet with valid/ready. Pipe: S1 operand regs, S2 products, S3 accumulate and
// result register. The whole pipe stalls together on adv.
// Build option DSP_SIMD_MAC_SAT_EN selects saturating lane reduction (see
// dsp_simd_sat_pack); default build wraps.
module dsp_simd_mac
    import dsp_simd_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int GUARD_W = GUARD_W_DEF
) (
    input  logic              CLK,
    input  logic              SCLR,
    input  logic              CE,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [1:0]        PREC,
    input  logic              FIRST,
    input  logic              LAST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [DATA_W-1:0] P,
    output logic [1:0]        P_PREC,
    output logic              OVF,
    output logic              OUT_VALID,
    input  logic              OUT_READY
);

    localparam int NL8    = lane_cnt(PREC_8, DATA_W);
    localparam int ACC_LW = MAX_ACC_W - GUARD_W_DEF + GUARD_W;

    logic                adv;
    prec_t               pkt_prec;

    logic                s1_valid, s1_first, s1_last;
    prec_t               s1_prec;
    logic [DATA_W-1:0]   s1_a, s1_b;

    logic                s2_valid, s2_first, s2_last;
    prec_t               s2_prec;
    logic [2*DATA_W-1:0] s2_prod;

    logic [2*DATA_W-1:0] prod_mode [4];
    logic [ACC_LW-1:0]   acc       [NL8];
    logic [ACC_LW-1:0]   acc_mode  [4][NL8];
    logic [ACC_LW-1:0]   acc_nxt   [NL8];
    logic [NL8*ACC_LW-1:0] acc_flat;
    logic [DATA_W-1:0]   p_nxt;
    logic                ovf_nxt;
    logic                out_load;

    assign adv      = CE & (~OUT_VALID | OUT_READY);
    assign IN_READY = adv & ~SCLR;
    assign out_load = s2_valid & s2_last;

    // S1 control: beat valid and the mode latched on each FIRST beat.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses <= only, so each stage samples its
        // upstream neighbour's value from before the edge.
        if (SCLR) begin
            s1_valid <= 1'b0;
            pkt_prec <= PREC_8;
        end else if (adv) begin
            s1_valid <= IN_VALID;
            if (IN_VALID && FIRST) pkt_prec <= prec_t'(PREC);
        end
    end

    // S1 data: operands and framing; non-FIRST beats inherit the latched mode.
    always_ff @(posedge CLK) begin
        // NOTE: data registers have no reset; every consumer qualifies them
        // with a valid bit, so only control state and accumulators are cleared.
        if (adv) begin
            s1_a     <= A;
            s1_b     <= B;
            s1_first <= FIRST;
            s1_last  <= LAST;
            s1_prec  <= FIRST ? prec_t'(PREC) : pkt_prec;
        end
    end

    // Per-mode lane products; lane i of mode m sits at [i*2LW +: 2LW].
    for (genvar m = 0; m < 4; m++) begin : g_mul
        localparam int LW = 8 << m;
        localparam int PW = 2 * LW;
        for (genvar i = 0; i < DATA_W / LW; i++) begin : g_lane
            assign prod_mode[m][i*PW +: PW] =
                PW'($signed(s1_a[i*LW +: LW])) * PW'($signed(s1_b[i*LW +: LW]));
        end
    end

    // S2 control: product-stage valid.
    always_ff @(posedge CLK) begin
        if (SCLR) s2_valid <= 1'b0;
        else if (adv) s2_valid <= s1_valid;
    end

    // S2 data: register the product bank of the beat's mode.
    always_ff @(posedge CLK) begin
        if (adv) begin
            s2_prod  <= prod_mode[s1_prec];
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_prec  <= s1_prec;
        end
    end

    // Per-mode accumulate; the sum wraps at ACC_W = 2LW+GUARD_W and is kept
    // sign-extended in the shared slot so reduction sees the wrapped value.
    for (genvar m = 0; m < 4; m++) begin : g_acc
        localparam int LW = 8 << m;
        localparam int PW = 2 * LW;
        localparam int AW = PW + GUARD_W;
        for (genvar i = 0; i < NL8; i++) begin : g_lane
            if (i < DATA_W / LW) begin : g_used
                logic [AW-1:0] base, sum;
                assign base = s2_first ? '0 : acc[i][AW-1:0];
                assign sum  = base + AW'($signed(s2_prod[i*PW +: PW]));
                assign acc_mode[m][i] = ACC_LW'($signed(sum));
            end else begin : g_idle
                assign acc_mode[m][i] = '0;
            end
        end
    end

    // Select the accumulator update of the packet's mode.
    always_comb begin
        // NOTE: every element is written on every pass, so no latch is inferred.
        for (int i = 0; i < NL8; i++) acc_nxt[i] = acc_mode[s2_prec][i];
    end

    for (genvar i = 0; i < NL8; i++) begin : g_flat
        assign acc_flat[i*ACC_LW +: ACC_LW] = acc_nxt[i];
    end

    dsp_simd_sat_pack #(
        .DATA_W (DATA_W),
        .ACC_LW (ACC_LW)
    ) u_sat_pack (
        .prec     (s2_prec),
        .acc_flat (acc_flat),
        .p        (p_nxt),
        .ovf      (ovf_nxt)
    );

    // S3 accumulator bank: update on each beat, clear after a LAST beat.
    always_ff @(posedge CLK) begin
        if (SCLR) begin
            for (int i = 0; i < NL8; i++) acc[i] <= '0;
        end else if (adv && s2_valid) begin
            for (int i = 0; i < NL8; i++) acc[i] <= s2_last ? '0 : acc_nxt[i];
        end
    end

    // Result register: load on LAST, drop valid on a handshake without reload.
    always_ff @(posedge CLK) begin
        if (SCLR) begin
            OUT_VALID <= 1'b0;
            P         <= '0;
            P_PREC    <= 2'd0;
            OVF       <= 1'b0;
        end else if (adv) begin
            OUT_VALID <= out_load;
            if (out_load) begin
                P      <= p_nxt;
                P_PREC <= s2_prec;
                OVF    <= ovf_nxt;
            end
        end
    end

endmodule

// File: doc/dsp_simd_mac.md
# dsp_simd_mac

Parametrised signed SIMD multiply-accumulate unit. It is the successor to the fixed 32/64-bit DSP multiply and MAC primitives in the DTPU datapath.

- One DATA_W-bit operand pair is split into 8/16/32/64-bit lanes, selected per packet.
- Each lane multiplies and accumulates over a multi-beat packet.
- One packed result word is emitted per packet, with a valid/ready handshake.
- The block sits between the operand fetch buffers and the result writeback FIFO of a DTPU processing element.

## Interface
Parameters:
- DATA_W, 64, operand/result width; must be a multiple of 64.
- GUARD_W, 8, extra accumulator bits per lane above 2×lane width.

Ports:
- CLK  in  1  clock; single clock domain.
- SCLR  in  1  synchronous active-high reset.
- CE  in  1  global enable; low freezes every register and forces IN_READY low.
- A  in  DATA_W  packed signed operand A.
- B  in  DATA_W  packed signed operand B.
- PREC  in  2  lane width: 0=8, 1=16, 2=32, 3=64 bits.
- FIRST  in  1  first beat of a packet; clears the accumulators.
- LAST  in  1  last beat of a packet; triggers output.
- IN_VALID  in  1  input beat valid.
- IN_READY  out  1  input beat accepted when IN_VALID&IN_READY.
- P  out  DATA_W  packed lane results; lane i occupies bits [i·LW +: LW].
- P_PREC  out  2  PREC value of the packet held on P.
- OVF  out  1  at least one lane saturated in this packet.
- OUT_VALID  out  1  P, P_PREC and OVF are valid.
- OUT_READY  in  1  downstream accepts when OUT_VALID&OUT_READY.

## Operation
- Lane width LW = 8<<PREC. Lane count = DATA_W/LW. All lanes are two's-complement signed.
- Pipeline advance: adv = CE & (~OUT_VALID | OUT_READY). IN_READY = adv. The whole pipe stalls together; there is no skid buffer.
- S1 registers A, B, FIRST, LAST and the valid bit. PREC is latched only on a FIRST beat. PREC on non-FIRST beats is ignored; the packet keeps its latched mode.
- S2 computes per-lane full product, 2·LW bits signed.
- S3 updates the per-lane accumulator, ACC_W = 2·LW+GUARD_W:
  - acc = (FIRST ? 0 : acc) + sign-extended product.
  - A beat with FIRST&LAST is a single-beat packet.
- On a LAST beat leaving S3:
  - Each lane is reduced to LW bits; see Configuration.
  - The reduced lanes are packed into P.
  - P_PREC is set to the packet's mode and OUT_VALID is set.
  - OVF is set to the OR of the per-lane saturation events.
- OUT_VALID clears on handshake, unless a new LAST beat loads the same edge; in that case it stays high with new data.
- A beat without FIRST after a completed packet continues accumulating from the cleared state. Accumulators clear after each LAST.
- Accumulator overflow beyond ACC_W wraps silently.

## Timing
- Reset values: IN_READY=0 during SCLR, then follows adv. P=0, P_PREC=0, OVF=0, OUT_VALID=0. All accumulators and pipeline valids are 0.
- Latency: LAST beat accepted in cycle n → OUT_VALID high in cycle n+3, with no stall.
- Throughput: one beat per cycle. Back-to-back single-beat packets give one result per cycle while OUT_READY=1.
- Stall: OUT_VALID=1 & OUT_READY=0 holds S1–S3 and P stable. IN_READY=0 the same cycle.
- CE=0 holds every register, including OUT_VALID. A handshake on OUT_READY is not taken while CE=0.
- SCLR mid-packet discards all in-flight beats and the held output. The next packet must start with FIRST.

## Configuration
- DSP_SIMD_MAC_SAT_EN defined: each lane result is clamped to [−2^(LW−1), 2^(LW−1)−1]. OVF reports any clamp.
- DSP_SIMD_MAC_SAT_EN undefined: each lane result is the low LW bits of the accumulator (wrap). OVF is tied to 0.

## Structure
- Shared package dsp_simd_pkg:
  - prec_t enum (PREC_8, PREC_16, PREC_32, PREC_64).
  - Functions lane_w(prec) and lane_cnt(prec, DATA_W).
  - Constant MAX_ACC_W = 128+GUARD_W.
- One sub-module, dsp_simd_sat_pack: per-mode reduction (saturate or wrap) and lane packing of the accumulator bank into P, plus OVF generation. It is purely combinational and instantiated once before the P register.

## Test plan
- PREC=1, DATA_W=64, 4 beats with every lane A=100, B=2 (FIRST on beat 0, LAST on beat 3) → P=0x0320_0320_0320_0320, OVF=0, OUT_VALID in cycle 3 after the last accept.
- PREC=3, single beat A=3, B=−2 → P=0xFFFF_FFFF_FFFF_FFFA, P_PREC=3.
- PREC=0, single beat, all lanes A=0x7F, B=0x7F:
  - With SAT_EN: P=0x7F7F_7F7F_7F7F_7F7F, OVF=1.
  - Without SAT_EN: P=0x0101_0101_0101_0101, OVF=0.
- Back-to-back single-beat packets with OUT_READY held low for 5 cycles → IN_READY=0 and P stable throughout. Release gives one result per cycle, none lost or duplicated.
- PREC changed from 0 to 2 on a non-FIRST beat mid-packet → result computed in 8-bit mode, P_PREC=0.
- SCLR asserted after 2 beats of a 4-beat packet → all outputs 0 next cycle. A new packet with FIRST produces the correct, uncorrupted result.
